hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RSA-decryption ASIP datapath. It tracks the register-write and load status of the instructions in EX, MEM and WB in shadow registers, and drives the datapath's operand-forwarding selects. It generates stall and bubble controls for load-use hazards and squashes wrong-path instructions after a taken branch. It sits beside the control decoder and is the only source of `forward_ra`, `forward_rb` and the pipeline hold/flush signals.

---
 rtl/hazard_unit.sv | 165 ++++++++++++++++
 tb/tb_hazard_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the five-stage RSA-decryption
// ASIP datapath. Tracks write/load status of the instructions in EX, MEM and
// WB, selects operand forwarding, stalls on load-use and squashes the
// wrong path after a taken branch. All outputs are combinational from the
// shadow state, the squash FSM and the current inputs.
module hazard_unit #(
  parameter int N           = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ra_id,
  input  logic [4:0] rb_id,
  input  logic [4:0] rw_id,
  input  logic       uses_ra_id,
  input  logic       uses_rb_id,
  input  logic       wr_en_id,
  input  logic       wd_sel_id,
  input  logic [4:0] ra_ex,
  input  logic [4:0] rb_ex,
  input  logic [4:0] rw_mem,
  input  logic [4:0] rw_wb,
  input  logic       branch_taken,
  output logic [1:0] forward_ra,
  output logic [1:0] forward_rb,
  output logic       stall_if,
  output logic       bubble_ex,
  output logic       flush_id
);

  // Forwarding select encodings seen by the datapath operand muxes.
  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;
  localparam logic [1:0] FwdWb  = 2'b10;

  // Squash window counter: wide enough to hold FLUSH_DEPTH.
  localparam int               FcntW      = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FcntW-1:0] FcntReload = FcntW'(FLUSH_DEPTH - 1);
  localparam logic [FcntW-1:0] FcntOne    = FcntW'(1);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  // Parameter consistency: a bad configuration stops elaboration.
  if (N < 1 || FLUSH_DEPTH < 1 || FLUSH_DEPTH > 3) begin : g_bad_params
    $error("hazard_unit: N must be positive and FLUSH_DEPTH must be 1..3");
  end

  // Shadow pipeline state.
  logic         r_ex_wr;
  logic         r_ex_load;
  logic [4:0]   r_rw_ex;
  logic         r_mem_wr;
  logic         r_mem_load;
  logic         r_wb_wr;

  // Branch squash FSM.
  state_t           r_state;
  logic [FcntW-1:0] r_fcnt;

  // Combinational decisions.
  logic [1:0] w_fwd_ra;
  logic [1:0] w_fwd_rb;
  logic       w_load_use;
  logic       w_flush;
  logic       w_bubble;

  // Forward A: MEM ALU result has priority over WB write data; r0 never forwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_fwd_ra = FwdRf;
    if (r_mem_wr && !r_mem_load && (rw_mem == ra_ex) && (ra_ex != 5'd0)) begin
      w_fwd_ra = FwdMem;
    end else if (r_wb_wr && (rw_wb == ra_ex) && (ra_ex != 5'd0)) begin
      w_fwd_ra = FwdWb;
    end
  end

  // Forward B: same priority rule applied to the rb operand.
  always_comb begin
    w_fwd_rb = FwdRf;
    if (r_mem_wr && !r_mem_load && (rw_mem == rb_ex) && (rb_ex != 5'd0)) begin
      w_fwd_rb = FwdMem;
    end else if (r_wb_wr && (rw_wb == rb_ex) && (rb_ex != 5'd0)) begin
      w_fwd_rb = FwdWb;
    end
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    w_load_use = 1'b0;
    if (r_ex_load && (r_rw_ex != 5'd0)) begin
      w_load_use = (uses_ra_id && (ra_id == r_rw_ex)) ||
                   (uses_rb_id && (rb_id == r_rw_ex));
    end
  end

  // Squash is active on the branch cycle itself and for the rest of the window;
  // reset gates the live branch input so flush drops as soon as reset rises.
  always_comb begin
    w_flush  = !reset && (branch_taken || (r_state == S_FLUSH));
    // A squashed dependent instruction needs no stall, but EX still gets a bubble.
    w_bubble = w_load_use || w_flush;
  end

  assign forward_ra = w_fwd_ra;
  assign forward_rb = w_fwd_rb;
  assign stall_if   = w_load_use && !w_flush;
  assign bubble_ex  = w_bubble;
  assign flush_id   = w_flush;

  // Advance the shadow write/load bits one stage per cycle; a bubble enters EX as a NOP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex_wr    <= 1'b0;
      r_ex_load  <= 1'b0;
      r_rw_ex    <= 5'd0;
      r_mem_wr   <= 1'b0;
      r_mem_load <= 1'b0;
      r_wb_wr    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      r_ex_wr    <= wr_en_id && !w_bubble;
      r_ex_load  <= wd_sel_id && wr_en_id && !w_bubble;
      r_rw_ex    <= rw_id;
      r_mem_wr   <= r_ex_wr;
      r_mem_load <= r_ex_load;
      r_wb_wr    <= r_mem_wr;
    end
  end

  // Squash window: a taken branch opens (or restarts) a FLUSH_DEPTH-cycle window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (branch_taken && (FLUSH_DEPTH > 1)) begin
            r_fcnt  <= FcntReload;
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (branch_taken) begin
            r_fcnt <= FcntReload;
          end else if (r_fcnt == FcntOne) begin
            r_fcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - FcntOne;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic, checked against
// an instruction-level pipeline model (records shifting through EX/MEM/WB and
// a "flush until cycle" window) kept in the bench.
module tb_hazard_unit;

  localparam int FD = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ra_id, rb_id, rw_id, ra_ex, rb_ex, rw_mem, rw_wb;
  logic       uses_ra_id, uses_rb_id, wr_en_id, wd_sel_id, branch_taken;
  logic [1:0] forward_ra, forward_rb;
  logic       stall_if, bubble_ex, flush_id;

  hazard_unit #(.N(32), .FLUSH_DEPTH(FD)) dut (
    .clock        (clock),
    .reset        (reset),
    .ra_id        (ra_id),
    .rb_id        (rb_id),
    .rw_id        (rw_id),
    .uses_ra_id   (uses_ra_id),
    .uses_rb_id   (uses_rb_id),
    .wr_en_id     (wr_en_id),
    .wd_sel_id    (wd_sel_id),
    .ra_ex        (ra_ex),
    .rb_ex        (rb_ex),
    .rw_mem       (rw_mem),
    .rw_wb        (rw_wb),
    .branch_taken (branch_taken),
    .forward_ra   (forward_ra),
    .forward_rb   (forward_rb),
    .stall_if     (stall_if),
    .bubble_ex    (bubble_ex),
    .flush_id     (flush_id)
  );

  always #5 clock = ~clock;

  // One in-flight instruction as the datapath sees it.
  typedef struct {
    logic       wr;
    logic       load;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rw;
  } instr_t;

  instr_t st_ex, st_mem, st_wb;
  instr_t nop_i;
  int     cyc;
  int     flush_last;   // last cycle index covered by the squash window
  logic   exp_stall, exp_bubble;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (st_mem.wr && !st_mem.load && st_mem.rw == src) return 2'd1;
    if (st_wb.wr && st_wb.rw == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    st_ex      = nop_i;
    st_mem     = nop_i;
    st_wb      = nop_i;
    flush_last = -1;
  endtask

  // Drive one cycle's inputs (called just after a falling edge) and check all outputs.
  task automatic apply(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                       input logic ua, input logic ub, input logic we, input logic ld,
                       input logic br);
    logic exp_flush, lu;
    ra_id = ra; rb_id = rb; rw_id = rw;
    uses_ra_id = ua; uses_rb_id = ub; wr_en_id = we; wd_sel_id = ld;
    branch_taken = br;
    ra_ex = st_ex.ra; rb_ex = st_ex.rb; rw_mem = st_mem.rw; rw_wb = st_wb.rw;
    #1;
    if (reset) begin
      exp_flush = 1'b0;
      lu        = 1'b0;
      check("fwd_a", {6'd0, forward_ra}, 8'd0);
      check("fwd_b", {6'd0, forward_rb}, 8'd0);
    end else begin
      exp_flush = br || (cyc <= flush_last);
      lu = st_ex.load && st_ex.rw != 5'd0 &&
           ((ua && ra == st_ex.rw) || (ub && rb == st_ex.rw));
      check("fwd_a", {6'd0, forward_ra}, {6'd0, model_fwd(st_ex.ra)});
      check("fwd_b", {6'd0, forward_rb}, {6'd0, model_fwd(st_ex.rb)});
    end
    exp_stall  = lu && !exp_flush;
    exp_bubble = lu || exp_flush;
    check("stall_if",  {7'd0, stall_if},  {7'd0, exp_stall});
    check("bubble_ex", {7'd0, bubble_ex}, {7'd0, exp_bubble});
    check("flush_id",  {7'd0, flush_id},  {7'd0, exp_flush});
  endtask

  // Clock the model forward and wait for the next falling edge.
  task automatic tick();
    if (reset) begin
      model_clear();
    end else begin
      st_wb  = st_mem;
      st_mem = st_ex;
      st_ex.ra   = ra_id;
      st_ex.rb   = rb_id;
      st_ex.rw   = rw_id;
      st_ex.wr   = wr_en_id && !exp_bubble;
      st_ex.load = wr_en_id && wd_sel_id && !exp_bubble;
      if (branch_taken) flush_last = cyc + FD - 1;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [4:0] r_a, r_b, r_w;
    logic       u_a, u_b, w_e, l_d, b_r;
    nop_i = '{wr: 1'b0, load: 1'b0, ra: 5'd0, rb: 5'd0, rw: 5'd0};
    model_clear();
    cyc = 0;
    exp_stall = 1'b0; exp_bubble = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    // Reset state, even with a branch request present.
    apply(5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_flush", {7'd0, flush_id}, 8'd0);
    tick();
    reset = 1'b0;
    idle_cycles(1);
    check("post_rst_stall", {7'd0, stall_if}, 8'd0);

    // ALU chain: add r3 ; sub r4,r3 ; or r5,?,r3
    apply(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    apply(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    apply(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("alu_fwd_mem", {6'd0, forward_ra}, 8'd1);
    tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("alu_fwd_wb", {6'd0, forward_rb}, 8'd2);
    tick();
    idle_cycles(2);

    // Load-use: ld r5 ; add r6,r5
    apply(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    apply(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_stall", {7'd0, stall_if}, 8'd1);
    check("lu_bubble", {7'd0, bubble_ex}, 8'd1);
    tick();
    apply(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_stall_once", {7'd0, stall_if}, 8'd0);
    tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_fwd_wb", {6'd0, forward_ra}, 8'd2);
    tick();
    idle_cycles(2);

    // Register 0: ld r0 then read r0 -> no stall, no forward.
    apply(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    apply(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("r0_no_stall", {7'd0, stall_if}, 8'd0);
    tick();
    apply(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("r0_no_fwd", {6'd0, forward_ra}, 8'd0);
    tick();
    idle_cycles(2);

    // Double writer of r7: MEM wins over WB.
    apply(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    apply(5'd2, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    apply(5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dbl_fwd_a", {6'd0, forward_ra}, 8'd1);
    check("dbl_fwd_b", {6'd0, forward_rb}, 8'd1);
    tick();
    idle_cycles(2);

    // Branch: single pulse -> exactly FD cycles of flush.
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("br_c1", {7'd0, flush_id}, 8'd1);
    tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_c2", {7'd0, flush_id}, 8'd1);
    tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_c3_off", {7'd0, flush_id}, 8'd0);
    tick();
    // Second pulse in cycle 2 extends the window to cycle 3.
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_ext_c3", {7'd0, flush_id}, 8'd1);
    tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_ext_c4_off", {7'd0, flush_id}, 8'd0);
    tick();
    // Load-use coincident with a taken branch: flush wins.
    apply(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    apply(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("br_lu_stall", {7'd0, stall_if}, 8'd0);
    check("br_lu_bubble", {7'd0, bubble_ex}, 8'd1);
    tick();
    idle_cycles(3);

    // Reset asserted inside the flush window drops flush at once.
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midflush_on", {7'd0, flush_id}, 8'd1);
    reset = 1'b1;
    #1;
    check("midflush_rst", {7'd0, flush_id}, 8'd0);
    check("midflush_rst_bub", {7'd0, bubble_ex}, 8'd0);
    tick();
    reset = 1'b0;
    apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst_flush", {7'd0, flush_id}, 8'd0);
    tick();

    // Randomized traffic; a stalled ID instruction is held, as the real IF/ID would.
    r_a = '0; r_b = '0; r_w = '0; u_a = 0; u_b = 0; w_e = 0; l_d = 0;
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall) begin
        r_a = 5'($urandom_range(0, 3));
        r_b = 5'($urandom_range(0, 3));
        r_w = 5'($urandom_range(0, 3));
        u_a = 1'($urandom_range(0, 1));
        u_b = 1'($urandom_range(0, 1));
        w_e = ($urandom_range(0, 3) != 0);
        l_d = ($urandom_range(0, 2) == 0);
      end
      b_r   = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 149) == 0);
      apply(r_a, r_b, r_w, u_a, u_b, w_e, l_d, b_r);
      tick();
    end
    reset = 1'b0;
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
